// File: rtl/bus_arb_dec_pkg.sv
// Shared definitions for the two-master / two-slave bus front end.
//   - arbiter state encoding (owner of the bus)
//   - read-return mux select codes
//   - default slave windows and hold limit
//   - rsel_code(): maps an access and its decode to a read-mux select
package bus_arb_dec_pkg;

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } arb_state_t;

  localparam logic [1:0] RSEL_DEF = 2'b00;
  localparam logic [1:0] RSEL_S0  = 2'b10;
  localparam logic [1:0] RSEL_S1  = 2'b01;

  localparam logic [7:0] DEF_S0_BASE   = 8'h00;
  localparam logic [7:0] DEF_S1_BASE   = 8'h20;
  localparam int         DEF_SPAN_BITS = 5;
  localparam int         DEF_MAX_HOLD  = 16;

  // Only a read that hit a slave steers the return mux; everything else
  // (write, miss, idle) falls back to the default source.
  function automatic logic [1:0] rsel_code(input logic rd, input logic s0,
                                           input logic s1);
    if (rd && s0)      return RSEL_S0;
    else if (rd && s1) return RSEL_S1;
    else               return RSEL_DEF;
  endfunction

endpackage

// File: rtl/bus_arb_dec_addr_dec.sv
// bus_addr_dec: combinational address decoder for the two slave windows.
// Ports:
//   addr    - routed address
//   en      - access qualifier (granted master is requesting)
//   s0_sel  - slave 0 select
//   s1_sel  - slave 1 select (suppressed whenever slave 0 also matches)
module bus_addr_dec
  import bus_arb_dec_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] S0_BASE     = ADDR_W'(DEF_S0_BASE),
  parameter logic [ADDR_W-1:0] S1_BASE     = ADDR_W'(DEF_S1_BASE),
  parameter int                S_SPAN_BITS = DEF_SPAN_BITS
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic              s0_sel,
  output logic              s1_sel
);

  logic hit0, hit1;

  assign hit0 = (addr[ADDR_W-1:S_SPAN_BITS] == S0_BASE[ADDR_W-1:S_SPAN_BITS]);
  assign hit1 = (addr[ADDR_W-1:S_SPAN_BITS] == S1_BASE[ADDR_W-1:S_SPAN_BITS]);

  // Slave 0 takes priority so overlapping windows never select both.
  assign s0_sel = en & hit0;
  assign s1_sel = en & hit1 & ~hit0;

endmodule

// File: rtl/bus_arb_dec.sv
// bus_arb_dec: request-side front end of the shared bus.
//   Arbitrates two masters (master 0 is the idle owner, hold-limited
//   hand-over when the other side is waiting), routes the owner's
//   address/write/data to the slaves, decodes slave selects, and registers
//   the read-return mux select one cycle after each access.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   m{0,1}_req/_wr/_addr/_dout - master request, write enable, address, data
//   m{0,1}_grant               - registered bus ownership
//   s_addr, s_wr, s_din        - routed slave-side request
//   s0_sel, s1_sel             - slave selects
//   rsel                       - registered read-mux select (10 s0, 01 s1)
module bus_arb_dec
  import bus_arb_dec_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] S0_BASE     = ADDR_W'(DEF_S0_BASE),
  parameter logic [ADDR_W-1:0] S1_BASE     = ADDR_W'(DEF_S1_BASE),
  parameter int                S_SPAN_BITS = DEF_SPAN_BITS,
  parameter int                MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic [1:0]        rsel
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        st, st_nxt;
  logic [HOLD_W-1:0] hold;
  logic              hold_max;
  logic              g_req, g_wr;

  assign hold_max = (hold == HOLD_LAST);

  assign m0_grant = (st == M0_GRANT);
  assign m1_grant = (st == M1_GRANT);

  // Owner mux: everything on the slave side follows the state register.
  always_comb begin
    g_req  = m0_req;
    g_wr   = m0_wr;
    s_addr = m0_addr;
    s_din  = m0_dout;
    if (st == M1_GRANT) begin
      g_req  = m1_req;
      g_wr   = m1_wr;
      s_addr = m1_addr;
      s_din  = m1_dout;
    end
  end

  assign s_wr = g_wr & g_req;

  bus_addr_dec #(
    .ADDR_W      (ADDR_W),
    .S0_BASE     (S0_BASE),
    .S1_BASE     (S1_BASE),
    .S_SPAN_BITS (S_SPAN_BITS)
  ) u_dec (
    .addr   (s_addr),
    .en     (g_req),
    .s0_sel (s0_sel),
    .s1_sel (s1_sel)
  );

  // Owner keeps the bus on simultaneous requests until its hold expires.
  always_comb begin
    st_nxt = st;
    case (st)
      M0_GRANT: if (m1_req && (!m0_req || hold_max)) st_nxt = M1_GRANT;
      M1_GRANT: if (!m1_req || (hold_max && m0_req)) st_nxt = M0_GRANT;
      default:  st_nxt = M0_GRANT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= M0_GRANT;
      hold <= '0;
      rsel <= RSEL_DEF;
    end else begin
      st <= st_nxt;
      // Counter saturates at the limit; it only matters once a competitor
      // shows up, at which point the limit forces the hand-over.
      if (st_nxt != st)          hold <= '0;
      else if (g_req && !hold_max) hold <= hold + 1'b1;
      rsel <= rsel_code(g_req & ~g_wr, s0_sel, s1_sel);
    end
  end

endmodule

// File: tb/tb_bus_arb_dec.sv
module tb_bus_arb_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant, s_wr, s0_sel, s1_sel;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic [1:0]  rsel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  bus_arb_dec dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din),
    .s0_sel(s0_sel), .s1_sel(s1_sel), .rsel(rsel)
  );

  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [7:0]  a0;
    logic [31:0] d0;
    bit          r1, w1;
    logic [7:0]  a1;
    logic [31:0] d1;
    bit          g0, g1, s0, s1, wr;
    logic [1:0]  rs;
    logic [7:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit rst, bit r0, bit w0, logic [7:0] a0,
                              logic [31:0] d0, bit r1, bit w1, logic [7:0] a1,
                              logic [31:0] d1, bit g0, bit g1, bit s0, bit s1,
                              bit wr, logic [1:0] rs, logic [7:0] ea,
                              logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.s0 = s0; v.s1 = s1; v.wr = wr; v.rs = rs;
    v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit r0, input bit w0,
                       input logic [7:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1,
                       input logic [31:0] d1);
    reset = rst; m0_req = r0; m0_wr = w0; m0_addr = a0; m0_dout = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_dout = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- reference model (behavioural) ----------------
  int         mo;     // current owner index
  int         mh;     // consecutive cycles counted for the owner
  logic [1:0] mr;     // read-mux select visible this cycle

  // window index = address / window size; slave 0 window 0, slave 1 window 1
  function automatic int slave_of(input logic [7:0] a);
    int w;
    w = int'(a) / 32;
    if (w == 8'h00 / 32) return 0;
    if (w == 8'h20 / 32) return 1;
    return -1;
  endfunction

  task automatic model_check();
    bit          req, wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          sl;
    req = (mo == 1) ? m1_req : m0_req;
    wr  = (mo == 1) ? m1_wr  : m0_wr;
    a   = (mo == 1) ? m1_addr : m0_addr;
    d   = (mo == 1) ? m1_dout : m0_dout;
    sl  = req ? slave_of(a) : -1;
    chk("m_grant0", 64'(m0_grant), 64'(mo == 0));
    chk("m_grant1", 64'(m1_grant), 64'(mo == 1));
    chk("m_saddr",  64'(s_addr), 64'(a));
    chk("m_sdin",   64'(s_din), 64'(d));
    chk("m_swr",    64'(s_wr), 64'(wr && req));
    chk("m_s0sel",  64'(s0_sel), 64'(sl == 0));
    chk("m_s1sel",  64'(s1_sel), 64'(sl == 1));
    chk("m_rsel",   64'(rsel), 64'(mr));
  endtask

  task automatic model_step();
    bit own_req, oth_req, own_wr, expired;
    int sl, nxt;
    own_req = (mo == 1) ? m1_req : m0_req;
    oth_req = (mo == 1) ? m0_req : m1_req;
    own_wr  = (mo == 1) ? m1_wr  : m0_wr;
    sl      = slave_of((mo == 1) ? m1_addr : m0_addr);
    if (reset) begin
      mo = 0; mh = 0; mr = 2'b00;
      return;
    end
    expired = (mh == 15);
    nxt = mo;
    if (mo == 0) begin
      if (oth_req && (!own_req || expired)) nxt = 1;
    end else begin
      if (!own_req || (expired && oth_req)) nxt = 0;
    end
    if (own_req && !own_wr && sl == 0)      mr = 2'b10;
    else if (own_req && !own_wr && sl == 1) mr = 2'b01;
    else                                    mr = 2'b00;
    if (nxt != mo)                mh = 0;
    else if (own_req && mh < 15)  mh++;
    mo = nxt;
  endtask

  initial begin
    // row: rst | m0 req wr addr data | m1 req wr addr data |
    //      g0 g1 s0 s1 wr rsel | s_addr s_din
    tbl[0]  = mk(1, 0,0,8'h00,32'h0,        1,0,8'h21,32'h0,        1,0,0,0,0,2'b00, 8'h00,32'h0);
    tbl[1]  = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'h0,        1,0,0,0,0,2'b00, 8'h00,32'h0);
    tbl[2]  = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'h0,        0,1,0,1,0,2'b00, 8'h21,32'h0);
    tbl[3]  = mk(0, 1,1,8'h05,32'hDEADBEEF, 0,0,8'h21,32'h0,        0,1,0,0,0,2'b01, 8'h21,32'h0);
    tbl[4]  = mk(0, 1,1,8'h05,32'hDEADBEEF, 0,0,8'h21,32'h0,        1,0,1,0,1,2'b00, 8'h05,32'hDEADBEEF);
    tbl[5]  = mk(0, 1,0,8'h21,32'h0,        0,0,8'h00,32'h0,        1,0,0,1,0,2'b00, 8'h21,32'h0);
    tbl[6]  = mk(0, 1,0,8'h03,32'h0,        0,0,8'h00,32'h0,        1,0,1,0,0,2'b01, 8'h03,32'h0);
    tbl[7]  = mk(0, 1,0,8'h80,32'h0,        0,0,8'h00,32'h0,        1,0,0,0,0,2'b10, 8'h80,32'h0);
    tbl[8]  = mk(0, 0,0,8'h80,32'h0,        0,0,8'h00,32'h0,        1,0,0,0,0,2'b00, 8'h80,32'h0);
    tbl[9]  = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'hCAFE0001, 1,0,0,0,0,2'b00, 8'h00,32'h0);
    tbl[10] = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'hCAFE0001, 0,1,0,1,0,2'b00, 8'h21,32'hCAFE0001);
    tbl[11] = mk(1, 0,0,8'h00,32'h0,        1,0,8'h21,32'hCAFE0001, 0,1,0,1,0,2'b01, 8'h21,32'hCAFE0001);
    tbl[12] = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'hCAFE0001, 1,0,0,0,0,2'b00, 8'h00,32'h0);
    tbl[13] = mk(0, 0,0,8'h00,32'h0,        1,0,8'h21,32'hCAFE0001, 0,1,0,1,0,2'b00, 8'h21,32'hCAFE0001);
    tbl[14] = mk(0, 0,0,8'h00,32'h0,        0,0,8'h21,32'hCAFE0001, 0,1,0,0,0,2'b01, 8'h21,32'hCAFE0001);
    tbl[15] = mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        1,0,0,0,0,2'b00, 8'h00,32'h0);

    mo = 0; mh = 0; mr = 2'b00;

    // initial reset
    drive(1, 0,0,8'h00,32'h0, 1,0,8'h00,32'h0);
    next_cycle();
    next_cycle();

    // ---------------- table-driven directed vectors ----------------
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #4;
      chk($sformatf("t%0d_g0", i),   64'(m0_grant), 64'(tbl[i].g0));
      chk($sformatf("t%0d_g1", i),   64'(m1_grant), 64'(tbl[i].g1));
      chk($sformatf("t%0d_s0", i),   64'(s0_sel),   64'(tbl[i].s0));
      chk($sformatf("t%0d_s1", i),   64'(s1_sel),   64'(tbl[i].s1));
      chk($sformatf("t%0d_wr", i),   64'(s_wr),     64'(tbl[i].wr));
      chk($sformatf("t%0d_rsel", i), 64'(rsel),     64'(tbl[i].rs));
      chk($sformatf("t%0d_addr", i), 64'(s_addr),   64'(tbl[i].ea));
      chk($sformatf("t%0d_din", i),  64'(s_din),    64'(tbl[i].ed));
      next_cycle();
    end

    // ---------------- both masters request continuously ----------------
    drive(1, 1,0,8'h90,32'h0, 1,0,8'h91,32'h0);
    next_cycle();
    reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #4;
      chk($sformatf("hold_c%0d_g0", c), 64'(m0_grant), 64'(c <= 16 || c >= 33));
      chk($sformatf("hold_c%0d_g1", c), 64'(m1_grant), 64'(c >= 17 && c <= 32));
      chk("hold_both_grants", 64'(m0_grant & m1_grant), 64'd0);
      next_cycle();
    end

    // ---------------- randomized against the reference model ----------------
    for (int i = 0; i < 3000; i++) begin
      drive(i == 0 || $urandom_range(0, 60) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 255)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 255)), $urandom);
      // occasionally bias addresses into the slave windows
      if ($urandom_range(0, 1) == 1) m0_addr = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) m1_addr = 8'($urandom_range(0, 63));
      #4;
      if (i > 0) model_check();
      model_step();
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
